// File: rtl/upstream_mem_responder_if.sv
// Request/acknowledge memory handshake between a downstream initiator and the
// upstream responder.
interface upstream_mem_responder_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              req;
    logic              memwr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;
    logic              busy;

    modport master (
        output req, memwr, addr, wdata,
        input  ack, rdata, busy
    );

    modport slave (
        input  req, memwr, addr, wdata,
        output ack, rdata, busy
    );
endinterface

// File: rtl/upstream_mem_responder.sv
// Upstream end of the req/ack/memwr handshake: serves reads and writes to a
// local memory after a programmable wait and zero-fills that memory after reset.
//
// state | meaning
// CLEAR | zero-filling memory after reset, requests ignored
// IDLE  | waiting for req
// WAIT  | request latched, counting down the wait latency
// ACK   | request served, ack held until req drops
module upstream_mem_responder #(
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 8,
    parameter int LATENCY = 2
) (
    input logic                     clk,
    input logic                     reset,
    upstream_mem_responder_if.slave bus
);
    localparam int         DEPTH    = 2 ** ADDR_W;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);
    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        CLEAR,
        IDLE,
        WAIT,
        ACK
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] clr_ptr;
    logic [ADDR_W-1:0] addr_l;
    logic [DATA_W-1:0] wdata_l;
    logic              memwr_l;
    logic [3:0]        cnt;
    logic              ack_r;
    logic              busy_r;
    logic [DATA_W-1:0] rdata_r;
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= CLEAR;
            clr_ptr <= '0;
            ack_r   <= 1'b0;
            rdata_r <= '0;
            busy_r  <= 1'b1;
            cnt     <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    mem[clr_ptr] <= '0;
                    // Pointer parks on the last word so it never wraps.
                    if (clr_ptr == CLR_LAST) begin
                        state  <= IDLE;
                        busy_r <= 1'b0;
                    end else begin
                        clr_ptr <= clr_ptr + 1'b1;
                    end
                end
                IDLE: begin
                    if (bus.req) begin
                        memwr_l <= bus.memwr;
                        addr_l  <= bus.addr;
                        wdata_l <= bus.wdata;
                        cnt     <= CNT_LOAD;
                        busy_r  <= 1'b1;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        if (memwr_l) begin
                            mem[addr_l] <= wdata_l;
                        end else begin
                            rdata_r <= mem[addr_l];
                        end
                        ack_r <= 1'b1;
                        state <= ACK;
                    end
                end
                ACK: begin
                    // A req already dropped during WAIT collapses ack to one cycle.
                    if (!bus.req) begin
                        ack_r  <= 1'b0;
                        busy_r <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    state <= CLEAR;
                end
            endcase
        end
    end

    assign bus.ack   = ack_r;
    assign bus.rdata = rdata_r;
    assign bus.busy  = busy_r;
endmodule

// File: tb/tb_upstream_mem_responder.sv
// Bench for upstream_mem_responder: LATENCY=2 and LATENCY=1 builds driven with
// identical stimulus and compared every cycle against a transaction-level model.
module tb_upstream_mem_responder;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       req;
    logic       memwr;
    logic [3:0] addr;
    logic [7:0] wdata;

    int checks   = 0;
    int errors   = 0;
    int edge_cnt = 0;
    bit started  = 0;

    always #5 clk = ~clk;

    upstream_mem_responder_if #(.ADDR_W(4), .DATA_W(8)) b0 ();
    upstream_mem_responder_if #(.ADDR_W(4), .DATA_W(8)) b1 ();

    assign b0.req   = req;
    assign b0.memwr = memwr;
    assign b0.addr  = addr;
    assign b0.wdata = wdata;
    assign b1.req   = req;
    assign b1.memwr = memwr;
    assign b1.addr  = addr;
    assign b1.wdata = wdata;

    upstream_mem_responder #(.ADDR_W(4), .DATA_W(8), .LATENCY(2)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (b0)
    );

    upstream_mem_responder #(.ADDR_W(4), .DATA_W(8), .LATENCY(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (b1)
    );

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : 1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Model: clear countdown, then one outstanding request that becomes due
    // LATENCY edges after acceptance and stays acknowledged until req is low.
    int         clear_left [2];
    int         due        [2];
    bit         pending    [2];
    bit         m_ack      [2];
    bit         m_busy     [2];
    bit         m_wr       [2];
    logic [3:0] m_addr     [2];
    logic [7:0] m_wd       [2];
    logic [7:0] m_rdata    [2];
    logic [7:0] m_mem      [2][DEPTH];

    always @(posedge clk) begin
        edge_cnt++;
        if (reset) started = 1;
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                clear_left[k] = DEPTH;
                pending[k]    = 0;
                m_ack[k]      = 0;
                m_rdata[k]    = 8'h00;
                m_busy[k]     = 1;
            end else if (clear_left[k] > 0) begin
                m_mem[k][DEPTH - clear_left[k]] = 8'h00;
                clear_left[k]--;
                m_busy[k] = (clear_left[k] > 0);
            end else if (m_ack[k]) begin
                if (!req) begin
                    m_ack[k]  = 0;
                    m_busy[k] = 0;
                end
            end else if (pending[k]) begin
                due[k]--;
                if (due[k] == 0) begin
                    if (m_wr[k]) m_mem[k][m_addr[k]] = m_wd[k];
                    else         m_rdata[k] = m_mem[k][m_addr[k]];
                    m_ack[k]   = 1;
                    pending[k] = 0;
                end
            end else if (req) begin
                m_wr[k]    = memwr;
                m_addr[k]  = addr;
                m_wd[k]    = wdata;
                due[k]     = lat_of(k);
                pending[k] = 1;
                m_busy[k]  = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("ack0",   b0.ack,   m_ack[0]);
            chk("busy0",  b0.busy,  m_busy[0]);
            chk("rdata0", b0.rdata, m_rdata[0]);
            chk("ack1",   b1.ack,   m_ack[1]);
            chk("busy1",  b1.busy,  m_busy[1]);
            chk("rdata1", b1.rdata, m_rdata[1]);
        end
    end

    task automatic wait_ack(input int start, input bit scramble,
                            output int l0, output int l1,
                            output logic [7:0] r0, output logic [7:0] r1);
        l0 = -1;
        l1 = -1;
        r0 = 8'h00;
        r1 = 8'h00;
        for (int i = 0; i < 60 && l0 < 0; i++) begin
            @(negedge clk);
            if (scramble) begin
                memwr = 1'($urandom);
                addr  = 4'($urandom);
                wdata = 8'($urandom);
            end
            if (b1.ack && l1 < 0) begin l1 = edge_cnt - start; r1 = b1.rdata; end
            if (b0.ack && l0 < 0) begin l0 = edge_cnt - start; r0 = b0.rdata; end
        end
        chk("ack_seen", (l0 >= 0), 1);
    endtask

    task automatic drop_req(input int hold);
        repeat (hold) @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        chk("ack_fall0", b0.ack, 0);
        chk("ack_fall1", b1.ack, 0);
    endtask

    task automatic txn(input bit wr, input logic [3:0] a, input logic [7:0] d, input int hold,
                       output int l0, output int l1, output logic [7:0] r0, output logic [7:0] r1);
        req   = 1'b1;
        memwr = wr;
        addr  = a;
        wdata = d;
        wait_ack(edge_cnt + 1, 1'b1, l0, l1, r0, r1);
        drop_req(hold);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((b0.busy || b1.busy) && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", (n < 60), 1);
    endtask

    initial begin
        int         n;
        int         rst_e;
        bit         bad;
        int         l0, l1;
        logic [7:0] r0, r1;

        reset = 1'b1;
        req   = 1'b0;
        memwr = 1'b0;
        addr  = 4'd0;
        wdata = 8'd0;
        @(negedge clk);
        reset = 1'b0;

        // Clear phase: busy for 16 cycles, outputs quiet.
        n   = 0;
        bad = 0;
        while (b0.busy && n < 40) begin
            if (b0.ack || b1.ack || b0.rdata != 8'h00 || b1.rdata != 8'h00) bad = 1;
            n++;
            @(negedge clk);
        end
        chk("t1_busy_cycles", n, 16);
        chk("t1_quiet", bad, 0);
        chk("t1_busy1_low", b1.busy, 0);

        txn(1'b1, 4'd3, 8'hA5, 2, l0, l1, r0, r1);
        chk("t2_lat0", l0, 2);
        chk("t2_lat1", l1, 1);

        txn(1'b0, 4'd3, 8'h00, 1, l0, l1, r0, r1);
        chk("t3_rd3_0", r0, 8'hA5);
        chk("t3_rd3_1", r1, 8'hA5);
        txn(1'b0, 4'd4, 8'h00, 0, l0, l1, r0, r1);
        chk("t3_rd4_0", r0, 8'h00);
        chk("t3_rd4_1", r1, 8'h00);

        // Request held through reset and clear.
        req   = 1'b1;
        memwr = 1'b0;
        addr  = 4'd3;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        rst_e = edge_cnt;
        wait_ack(rst_e, 1'b0, l0, l1, r0, r1);
        chk("t4_lat0", l0, 19);
        chk("t4_lat1", l1, 18);
        chk("t4_rd_cleared", r0, 8'h00);
        drop_req(0);

        // Reset during the wait of a write.
        req   = 1'b1;
        memwr = 1'b1;
        addr  = 4'd7;
        wdata = 8'h3C;
        @(negedge clk);
        reset = 1'b1;
        req   = 1'b0;
        @(negedge clk);
        chk("t5_ack0", b0.ack, 0);
        chk("t5_ack1", b1.ack, 0);
        reset = 1'b0;
        wait_idle();
        txn(1'b0, 4'd7, 8'h00, 0, l0, l1, r0, r1);
        chk("t5_rd7_0", r0, 8'h00);
        chk("t5_rd7_1", r1, 8'h00);

        // Back-to-back write then read.
        txn(1'b1, 4'd1, 8'h11, 0, l0, l1, r0, r1);
        txn(1'b0, 4'd1, 8'h00, 0, l0, l1, r0, r1);
        chk("t6_rd1_0", r0, 8'h11);
        chk("t6_rd1_1", r1, 8'h11);
        chk("t6_lat0", l0, 2);
        chk("t6_lat1", l1, 1);

        for (int it = 0; it < 200; it++) begin
            int sel;
            sel = $urandom_range(0, 19);
            if (sel == 0) begin
                req   = 1'b1;
                memwr = 1'($urandom);
                addr  = 4'($urandom);
                wdata = 8'($urandom);
                repeat ($urandom_range(0, 3)) @(negedge clk);
                reset = 1'b1;
                req   = 1'b0;
                @(negedge clk);
                reset = 1'b0;
                wait_idle();
            end else if (sel < 3) begin
                req   = 1'b1;
                memwr = 1'($urandom);
                addr  = 4'($urandom);
                wdata = 8'($urandom);
                @(negedge clk);
                req = 1'b0;
                repeat (4) @(negedge clk);
            end else begin
                txn(1'($urandom), 4'($urandom), 8'($urandom), $urandom_range(0, 2), l0, l1, r0, r1);
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end
endmodule
